// File: rtl/mux_n_to_1_reg.sv
// Registered N-input multiplexer for pipeline-stage selection.
// Selects by explicit sel or an internal round-robin pointer; flags out-of-range selects.
module mux_n_to_1_reg #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = 3,
    parameter int MODE   = 0
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic [NUM_IN*WIDTH-1:0] inBus,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    inValid,
    input  logic                    stall,
    input  logic                    flush,
    output logic [WIDTH-1:0]        out,
    output logic                    outValid,
    output logic [SEL_W-1:0]        outSel,
    output logic                    selErr
);

    localparam logic [SEL_W:0]   NUM_IN_W = (SEL_W+1)'(NUM_IN);
    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_IN - 1);

    logic [WIDTH-1:0] out_q,      out_d;
    logic             out_valid_q, out_valid_d;
    logic [SEL_W-1:0] out_sel_q,  out_sel_d;
    logic             sel_err_q,  sel_err_d;
    logic [SEL_W-1:0] rr_ptr_q,   rr_ptr_d;

    logic [SEL_W-1:0] sel_eff;
    logic             sel_in_range;
    logic [WIDTH-1:0] chan_data;
    logic             load;

    assign sel_eff      = (MODE == 1) ? rr_ptr_q : sel;
    assign sel_in_range = ({1'b0, sel_eff} < NUM_IN_W);
    assign load         = inValid && !stall && !flush;

    // Out-of-range selects fall through with zero data.
    always_comb begin
        chan_data = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (sel_eff == SEL_W'(k)) begin
                chan_data = inBus[k*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        out_d       = out_q;
        out_valid_d = out_valid_q;
        out_sel_d   = out_sel_q;
        sel_err_d   = sel_err_q;
        rr_ptr_d    = rr_ptr_q;

        if (flush) begin
            out_d       = '0;
            out_valid_d = 1'b0;
            sel_err_d   = 1'b0;
        end else if (stall) begin
            // everything holds
        end else if (load) begin
            out_valid_d = 1'b1;
            out_sel_d   = sel_eff;
            out_d       = sel_in_range ? chan_data : '0;
            sel_err_d   = !sel_in_range;
            // Pointer wraps at NUM_IN, not at 2^SEL_W, so it never goes out of range.
            if (MODE == 1) begin
                rr_ptr_d = (rr_ptr_q == LAST_IDX) ? '0 : rr_ptr_q + 1'b1;
            end
        end else begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
            out_sel_q   <= '0;
            sel_err_q   <= 1'b0;
            rr_ptr_q    <= '0;
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            out_sel_q   <= out_sel_d;
            sel_err_q   <= sel_err_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign out      = out_q;
    assign outValid = out_valid_q;
    assign outSel   = out_sel_q;
    assign selErr   = sel_err_q;

endmodule

// File: tb/tb_mux_n_to_1_reg.sv
// Directed bench for mux_n_to_1_reg: one explicit-select and one round-robin instance
// driven from shared inputs, checked against hand-computed values.
module tb_mux_n_to_1_reg;

    localparam int WIDTH  = 5;
    localparam int NUM_IN = 4;
    localparam int SEL_W  = 3;

    logic                    Clk = 1'b0;
    logic                    Reset;
    logic [NUM_IN*WIDTH-1:0] inBus;
    logic [SEL_W-1:0]        sel;
    logic                    inValid;
    logic                    stall;
    logic                    flush;

    logic [WIDTH-1:0] m0_out,  m1_out;
    logic             m0_vld,  m1_vld;
    logic [SEL_W-1:0] m0_sel,  m1_sel;
    logic             m0_err,  m1_err;

    int errors = 0;
    int checks = 0;

    always #5 Clk = ~Clk;

    mux_n_to_1_reg #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .SEL_W(SEL_W), .MODE(0)) u_m0 (
        .Clk(Clk), .Reset(Reset), .inBus(inBus), .sel(sel), .inValid(inValid),
        .stall(stall), .flush(flush), .out(m0_out), .outValid(m0_vld),
        .outSel(m0_sel), .selErr(m0_err)
    );

    mux_n_to_1_reg #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .SEL_W(SEL_W), .MODE(1)) u_m1 (
        .Clk(Clk), .Reset(Reset), .inBus(inBus), .sel(sel), .inValid(inValid),
        .stall(stall), .flush(flush), .out(m1_out), .outValid(m1_vld),
        .outSel(m1_sel), .selErr(m1_err)
    );

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_m0(input string tag, input logic [WIDTH-1:0] e_out, input logic e_vld,
                            input logic [SEL_W-1:0] e_sel, input logic e_err);
        check({tag, ".out"},      32'(m0_out), 32'(e_out));
        check({tag, ".outValid"}, 32'(m0_vld), 32'(e_vld));
        check({tag, ".outSel"},   32'(m0_sel), 32'(e_sel));
        check({tag, ".selErr"},   32'(m0_err), 32'(e_err));
    endtask

    task automatic check_m1(input string tag, input logic [WIDTH-1:0] e_out, input logic e_vld,
                            input logic [SEL_W-1:0] e_sel, input logic e_err);
        check({tag, ".rr_out"},      32'(m1_out), 32'(e_out));
        check({tag, ".rr_outValid"}, 32'(m1_vld), 32'(e_vld));
        check({tag, ".rr_outSel"},   32'(m1_sel), 32'(e_sel));
        check({tag, ".rr_selErr"},   32'(m1_err), 32'(e_err));
    endtask

    initial begin
        inBus   = {5'h1F, 5'h03, 5'h14, 5'h11};
        Reset   = 1'b1;
        stall   = 1'b1;
        flush   = 1'b0;
        inValid = 1'b1;
        sel     = 3'd3;

        // Reset with stall and live inputs
        step();
        step();
        check_m0("reset", 5'h00, 1'b0, 3'd0, 1'b0);
        check_m1("reset", 5'h00, 1'b0, 3'd0, 1'b0);

        Reset   = 1'b0;
        stall   = 1'b0;
        inValid = 1'b0;
        step();
        check_m0("post_reset_idle", 5'h00, 1'b0, 3'd0, 1'b0);
        check_m1("post_reset_idle", 5'h00, 1'b0, 3'd0, 1'b0);

        // Explicit select
        inValid = 1'b1;
        sel     = 3'd2;
        step();
        check_m0("sel2", 5'h03, 1'b1, 3'd2, 1'b0);
        sel = 3'd0;
        step();
        check_m0("sel0", 5'h11, 1'b1, 3'd0, 1'b0);

        // Out of range and recovery
        sel = 3'd5;
        step();
        check_m0("sel5_oor", 5'h00, 1'b1, 3'd5, 1'b1);
        sel = 3'd1;
        step();
        check_m0("sel1_after_oor", 5'h14, 1'b1, 3'd1, 1'b0);

        // Stall: new sel/inValid ignored for three edges
        stall = 1'b1;
        sel   = 3'd3;
        for (int i = 0; i < 3; i++) begin
            step();
            check_m0("stall_hold", 5'h14, 1'b1, 3'd1, 1'b0);
        end
        stall = 1'b0;
        step();
        check_m0("stall_release", 5'h1F, 1'b1, 3'd3, 1'b0);

        // Flush beats stall and load; outSel holds, selErr clears
        sel = 3'd6;
        step();
        check_m0("sel6_oor", 5'h00, 1'b1, 3'd6, 1'b1);
        flush = 1'b1;
        stall = 1'b1;
        sel   = 3'd0;
        step();
        check_m0("flush", 5'h00, 1'b0, 3'd6, 1'b0);
        flush   = 1'b0;
        stall   = 1'b0;
        inValid = 1'b0;
        step();
        check_m0("after_flush_idle", 5'h00, 1'b0, 3'd6, 1'b0);

        // Idle holds data and select
        inValid = 1'b1;
        sel     = 3'd3;
        step();
        check_m0("load3", 5'h1F, 1'b1, 3'd3, 1'b0);
        inValid = 1'b0;
        sel     = 3'd0;
        step();
        check_m0("idle_hold", 5'h1F, 1'b0, 3'd3, 1'b0);

        // Round robin from a clean reset
        Reset = 1'b1;
        step();
        check_m1("rr_reset", 5'h00, 1'b0, 3'd0, 1'b0);
        Reset   = 1'b0;
        inValid = 1'b1;
        sel     = 3'd7;
        step(); check_m1("rr0", 5'h11, 1'b1, 3'd0, 1'b0);
        step(); check_m1("rr1", 5'h14, 1'b1, 3'd1, 1'b0);
        step(); check_m1("rr2", 5'h03, 1'b1, 3'd2, 1'b0);
        step(); check_m1("rr3", 5'h1F, 1'b1, 3'd3, 1'b0);
        step(); check_m1("rr_wrap", 5'h11, 1'b1, 3'd0, 1'b0);

        inValid = 1'b0;
        step();
        check_m1("rr_idle", 5'h11, 1'b0, 3'd0, 1'b0);
        inValid = 1'b1;
        step();
        check_m1("rr_resume", 5'h14, 1'b1, 3'd1, 1'b0);

        // Stall must not advance the pointer
        stall = 1'b1;
        step();
        step();
        check_m1("rr_stall", 5'h14, 1'b1, 3'd1, 1'b0);
        stall = 1'b0;
        step();
        check_m1("rr_after_stall", 5'h03, 1'b1, 3'd2, 1'b0);

        // Reset mid-sequence restarts at channel 0
        Reset = 1'b1;
        step();
        check_m1("rr_mid_reset", 5'h00, 1'b0, 3'd0, 1'b0);
        Reset = 1'b0;
        step();
        check_m1("rr_restart", 5'h11, 1'b1, 3'd0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
